mem_arbiter: RTL and testbench

// - Shares one single-port, variable-latency memory between CPU instruction fetch and data load/store.
// - Uses request/valid handshakes and stalls the CPU pipeline through the valid pulses.
// - Steers bytes for stores, using the CPU memsize encoding (01=byte, 10=half, 11=word, 00=none).
// - Aligns load data to bit 0 so the CPU's existing sign/zero extension applies unchanged.
// - Sits between the CPU core and the memory model / BRAM.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_lane.sv | 54 +++++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU memory arbiter.
//   arb_state_t : arbiter FSM state encoding (also exported on the debug port)
//   MSZ_*       : CPU memsize encoding, shared with the CPU store-size logic
//   NOP_INST    : instruction word returned when a fetch times out
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [1:0] MSZ_NONE = 2'b00;
  localparam logic [1:0] MSZ_BYTE = 2'b01;
  localparam logic [1:0] MSZ_HALF = 2'b10;
  localparam logic [1:0] MSZ_WORD = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane steering between the CPU and a 32-bit memory word.
// Ports:
//   size          in  2   memsize encoding (MSZ_*)
//   off           in  2   byte offset within the word (addr[1:0])
//   wdata         in  32  right-aligned store data from the CPU
//   rdata         in  32  full word read from memory
//   be            out 4   byte enables for a store
//   mwdata        out 32  store data replicated across all candidate lanes
//   rdata_aligned out 32  read word shifted so the addressed byte lands at bit 0
//   misalign      out 1   half on an odd address, or word not on a word boundary
module mem_lane
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] mwdata,
  output logic [31:0] rdata_aligned,
  output logic        misalign
);

  // Plain shift only; the CPU applies its own sign/zero extension.
  assign rdata_aligned = rdata >> {off, 3'b000};

  always_comb begin
    be       = 4'b0000;
    mwdata   = 32'h0000_0000;
    misalign = 1'b0;
    case (size)
      MSZ_BYTE: begin
        be     = 4'b0001 << off;
        mwdata = {4{wdata[7:0]}};
      end
      MSZ_HALF: begin
        be       = 4'b0011 << off;
        mwdata   = {2{wdata[15:0]}};
        misalign = off[0];
      end
      MSZ_WORD: begin
        be       = 4'b1111;
        mwdata   = wdata;
        misalign = (off != 2'b00);
      end
      default: begin
        be       = 4'b0000;
        mwdata   = 32'h0000_0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory between CPU instruction
// fetch and data load/store.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_ireq, i_iaddr               fetch request / word address
//   o_ivalid, o_irdata            fetch completion pulse / instruction word
//   i_dreq, i_dwrite, i_daddr,
//   i_dsize, i_dwdata             data request, store flag, byte address, size, store data
//   o_dvalid, o_drdata, o_derr    data completion pulse / aligned load data / error
//   o_mreq, o_mwe, o_maddr,
//   o_mbe, o_mwdata               memory request side (registered, stable while o_mreq=1)
//   i_mrdata, i_mready            memory read word / completion
//   o_dbg_state                   current FSM state
//
// Handshake: a requester raises i_ireq or i_dreq with its inputs stable and
// holds them until the matching one-cycle o_ivalid / o_dvalid pulse; in that
// pulse cycle it either drops the request or presents a new one, because a
// request seen high in IDLE is always treated as new. On the memory side
// o_mreq and its address/data stay constant until the cycle i_mready=1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ireq,
  input  logic [ADDR_W-1:0] i_iaddr,
  output logic              o_ivalid,
  output logic [31:0]       o_irdata,
  input  logic              i_dreq,
  input  logic              i_dwrite,
  input  logic [ADDR_W-1:0] i_daddr,
  input  logic [1:0]        i_dsize,
  input  logic [31:0]       i_dwdata,
  output logic              o_dvalid,
  output logic [31:0]       o_drdata,
  output logic              o_derr,
  output logic              o_mreq,
  output logic              o_mwe,
  output logic [ADDR_W-1:0] o_maddr,
  output logic [3:0]        o_mbe,
  output logic [31:0]       o_mwdata,
  input  logic [31:0]       i_mrdata,
  input  logic              i_mready,
  output arb_state_t        o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int STK_W = $clog2(MAX_DSTREAK + 1);

  arb_state_t       state;
  logic             gnt_data;   // 1 = current transaction belongs to the data port
  logic             lat_we;
  logic [1:0]       lat_off;
  logic [CNT_W-1:0] tcnt;
  logic [STK_W-1:0] streak;

  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misalign;
  logic        data_win;
  logic        bypass;
  logic [1:0]  unused_iaddr;

  assign unused_iaddr = i_iaddr[1:0];
  assign o_dbg_state  = state;

  // In IDLE the lane looks at the live request; afterwards only the latched
  // offset matters, for aligning the returned read word.
  assign lane_off = (state == IDLE) ? i_daddr[1:0] : lat_off;

  mem_lane u_lane (
    .size          (i_dsize),
    .off           (lane_off),
    .wdata         (i_dwdata),
    .rdata         (i_mrdata),
    .be            (lane_be),
    .mwdata        (lane_wdata),
    .rdata_aligned (lane_rdata),
    .misalign      (lane_misalign)
  );

  // Data has priority, but a pending fetch is let through after
  // MAX_DSTREAK consecutive data grants so instruction flow never starves.
  assign data_win = i_dreq && (!i_ireq || (streak != STK_W'(MAX_DSTREAK)));
  assign bypass   = (i_dsize == MSZ_NONE) || lane_misalign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      gnt_data <= 1'b0;
      lat_we   <= 1'b0;
      lat_off  <= 2'b00;
      tcnt     <= '0;
      streak   <= '0;
      o_ivalid <= 1'b0;
      o_irdata <= 32'h0;
      o_dvalid <= 1'b0;
      o_drdata <= 32'h0;
      o_derr   <= 1'b0;
      o_mreq   <= 1'b0;
      o_mwe    <= 1'b0;
      o_maddr  <= '0;
      o_mbe    <= 4'b0000;
      o_mwdata <= 32'h0;
    end else begin
      o_ivalid <= 1'b0;
      o_dvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_ireq) streak <= '0;
          if (data_win) begin
            gnt_data <= 1'b1;
            lat_we   <= i_dwrite;
            lat_off  <= i_daddr[1:0];
            if (i_ireq) streak <= streak + 1'b1;
            if (bypass) begin
              // No-op or misaligned: answer directly without touching memory.
              state    <= RESP;
              o_dvalid <= 1'b1;
              o_derr   <= lane_misalign;
              o_drdata <= 32'h0;
            end else begin
              state    <= MEM;
              tcnt     <= '0;
              o_mreq   <= 1'b1;
              o_mwe    <= i_dwrite;
              o_maddr  <= {i_daddr[ADDR_W-1:2], 2'b00};
              o_mbe    <= i_dwrite ? lane_be : 4'b0000;
              o_mwdata <= i_dwrite ? lane_wdata : 32'h0;
            end
          end else if (i_ireq) begin
            gnt_data <= 1'b0;
            streak   <= '0;
            state    <= MEM;
            tcnt     <= '0;
            o_mreq   <= 1'b1;
            o_mwe    <= 1'b0;
            o_maddr  <= {i_iaddr[ADDR_W-1:2], 2'b00};
            o_mbe    <= 4'b0000;
            o_mwdata <= 32'h0;
          end
        end
        MEM: begin
          if (i_mready) begin
            state  <= RESP;
            o_mreq <= 1'b0;
            o_mwe  <= 1'b0;
            o_mbe  <= 4'b0000;
            if (gnt_data) begin
              o_dvalid <= 1'b1;
              o_derr   <= 1'b0;
              o_drdata <= lat_we ? 32'h0 : lane_rdata;
            end else begin
              o_ivalid <= 1'b1;
              o_irdata <= i_mrdata;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            // tcnt reaches TIMEOUT together with this abort.
            if (tcnt == CNT_W'(TIMEOUT - 1)) begin
              state  <= RESP;
              o_mreq <= 1'b0;
              o_mwe  <= 1'b0;
              o_mbe  <= 4'b0000;
              if (gnt_data) begin
                o_dvalid <= 1'b1;
                o_derr   <= 1'b1;
                o_drdata <= 32'h0;
              end else begin
                o_ivalid <= 1'b1;
                o_irdata <= NOP_INST;
              end
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int TIMEOUT     = 255;
  localparam int MAX_DSTREAK = 4;
  localparam logic [31:0] NO_CYC = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        is_d;
    logic        chk_data;
    logic        err;
    logic [31:0] data;
    logic [31:0] cyc;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cyc;
  } mreq_t;

  localparam int RW = $bits(rsp_t);
  localparam int MW = $bits(mreq_t);

  logic              i_clk;
  logic              i_rst;
  logic              i_ireq;
  logic [ADDR_W-1:0] i_iaddr;
  logic              o_ivalid;
  logic [31:0]       o_irdata;
  logic              i_dreq;
  logic              i_dwrite;
  logic [ADDR_W-1:0] i_daddr;
  logic [1:0]        i_dsize;
  logic [31:0]       i_dwdata;
  logic              o_dvalid;
  logic [31:0]       o_drdata;
  logic              o_derr;
  logic              o_mreq;
  logic              o_mwe;
  logic [ADDR_W-1:0] o_maddr;
  logic [3:0]        o_mbe;
  logic [31:0]       o_mwdata;
  logic [31:0]       i_mrdata;
  logic              i_mready;
  arb_state_t        o_dbg_state;

  logic [RW-1:0] exp_q[$];
  logic [MW-1:0] exp_m[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_waits = 0;
  int wcnt = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .MAX_DSTREAK(MAX_DSTREAK)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_ivalid(o_ivalid), .o_irdata(o_irdata),
    .i_dreq(i_dreq), .i_dwrite(i_dwrite), .i_daddr(i_daddr), .i_dsize(i_dsize),
    .i_dwdata(i_dwdata), .o_dvalid(o_dvalid), .o_drdata(o_drdata), .o_derr(o_derr),
    .o_mreq(o_mreq), .o_mwe(o_mwe), .o_maddr(o_maddr), .o_mbe(o_mbe), .o_mwdata(o_mwdata),
    .i_mrdata(i_mrdata), .i_mready(i_mready), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: mem_word = 32'h0050_0093;
      32'h300: mem_word = 32'hBEEF_1234;
      default: mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic push_rsp(input logic is_d, input logic chk, input logic err,
                          input logic [31:0] data, input logic [31:0] c);
    rsp_t r;
    r = '{is_d: is_d, chk_data: chk, err: err, data: data, cyc: c};
    exp_q.push_back(r);
  endtask

  task automatic push_m(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] c);
    mreq_t m;
    m = '{we: we, be: be, addr: addr, wdata: wdata, cyc: c};
    exp_m.push_back(m);
  endtask

  // ---------------- memory model ----------------
  always @(negedge i_clk) begin
    if (o_mreq) begin
      i_mready = (wcnt >= mem_waits);
      i_mrdata = mem_word(o_maddr);
      wcnt = wcnt + 1;
    end else begin
      i_mready = 1'b0;
      i_mrdata = 32'h0;
      wcnt = 0;
    end
  end

  // ---------------- memory-side scoreboard ----------------
  logic prev_mreq = 1'b0;
  logic [68:0] cur_m;
  always @(negedge i_clk) begin
    mreq_t e;
    if (o_mreq && !prev_mreq) begin
      if (exp_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mreq: got mreq addr %h expected no memory cycle", o_maddr);
      end else begin
        e = exp_m.pop_front();
        check("mem_we", {31'b0, o_mwe}, {31'b0, e.we});
        check("mem_be", {28'b0, o_mbe}, {28'b0, e.be});
        check("mem_addr", o_maddr, e.addr);
        check("mem_wdata", o_mwdata, e.wdata);
        if (e.cyc != NO_CYC) check("mem_cycle", cyc, e.cyc);
      end
      cur_m = {o_mwe, o_mbe, o_maddr, o_mwdata};
    end else if (o_mreq && prev_mreq) begin
      check("mem_stable", {31'b0, cur_m == {o_mwe, o_mbe, o_maddr, o_mwdata}}, 32'd1);
    end
    prev_mreq = o_mreq;
  end

  // ---------------- response scoreboard ----------------
  always @(negedge i_clk) begin
    rsp_t e;
    if (o_ivalid || o_dvalid) begin
      check("one_valid", {31'b0, o_ivalid & o_dvalid}, 32'd0);
      check("mreq_low_at_valid", {31'b0, o_mreq}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got ivalid=%b dvalid=%b expected none", o_ivalid, o_dvalid);
      end else begin
        e = exp_q.pop_front();
        check("rsp_kind_dvalid", {31'b0, o_dvalid}, {31'b0, e.is_d});
        if (e.is_d) begin
          if (e.chk_data) check("drdata", o_drdata, e.data);
          check("derr", {31'b0, o_derr}, {31'b0, e.err});
        end else begin
          check("irdata", o_irdata, e.data);
        end
        if (e.cyc != NO_CYC) check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- drivers (entered at a negedge) ----------------
  task automatic wait_valid(input logic is_d);
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      if (is_d ? o_dvalid : o_ivalid) return;
    end
    checks++;
    errors++;
    $display("FAIL valid_timeout: got no %s pulse expected one within 400 cycles", is_d ? "dvalid" : "ivalid");
  endtask

  task automatic fetch_txn(input logic [31:0] addr);
    i_ireq  = 1'b1;
    i_iaddr = addr;
    wait_valid(1'b0);
  endtask

  task automatic data_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
    i_dreq   = 1'b1;
    i_dwrite = wr;
    i_daddr  = addr;
    i_dsize  = size;
    i_dwdata = wdata;
    wait_valid(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int s;
    i_rst = 1'b1; i_ireq = 1'b0; i_iaddr = '0; i_dreq = 1'b0; i_dwrite = 1'b0;
    i_daddr = '0; i_dsize = MSZ_NONE; i_dwdata = 32'h0; i_mready = 1'b0; i_mrdata = 32'h0;
    idle(3);
    check("reset_outputs",
          {27'b0, o_ivalid, o_dvalid, o_derr, o_mreq, o_mwe}, 32'd0);
    check("reset_buses", o_irdata | o_drdata | o_maddr | o_mwdata | {28'b0, o_mbe}, 32'd0);
    check("reset_state", {30'b0, o_dbg_state}, {30'b0, IDLE});
    i_rst = 1'b0;
    idle(2);

    // fetch, zero wait
    s = cyc;
    push_m(1'b0, 4'b0000, 32'h100, 32'h0, s + 1);
    push_rsp(1'b0, 1'b1, 1'b0, 32'h0050_0093, s + 2);
    fetch_txn(32'h100);
    i_ireq = 1'b0;
    idle(2);

    // stores: byte at offset 3, half at offset 2, word
    s = cyc;
    push_m(1'b1, 4'b1000, 32'h200, 32'hABAB_ABAB, s + 1);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, s + 2);
    data_txn(1'b1, 32'h203, MSZ_BYTE, 32'h0000_00AB);
    i_dreq = 1'b0;
    idle(2);
    s = cyc;
    push_m(1'b1, 4'b1100, 32'h400, 32'hCDEF_CDEF, s + 1);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, s + 2);
    data_txn(1'b1, 32'h402, MSZ_HALF, 32'h1234_CDEF);
    i_dreq = 1'b0;
    idle(2);
    s = cyc;
    push_m(1'b1, 4'b1111, 32'h404, 32'hDEAD_BEEF, s + 1);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, s + 2);
    data_txn(1'b1, 32'h404, MSZ_WORD, 32'hDEAD_BEEF);
    i_dreq = 1'b0;
    idle(2);

    // load half with 3 wait cycles, then load byte zero-wait
    mem_waits = 3;
    s = cyc;
    push_m(1'b0, 4'b0000, 32'h300, 32'h0, s + 1);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h0000_BEEF, s + 5);
    data_txn(1'b0, 32'h302, MSZ_HALF, 32'h0);
    i_dreq = 1'b0;
    mem_waits = 0;
    idle(2);
    s = cyc;
    push_m(1'b0, 4'b0000, 32'h300, 32'h0, s + 1);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h00BE_EF12, s + 2);
    data_txn(1'b0, 32'h301, MSZ_BYTE, 32'h0);
    i_dreq = 1'b0;
    idle(2);

    // bypass cases: misaligned word, misaligned half store, size none
    s = cyc;
    push_rsp(1'b1, 1'b1, 1'b1, 32'h0, s + 1);
    data_txn(1'b0, 32'h401, MSZ_WORD, 32'h0);
    i_dreq = 1'b0;
    idle(2);
    s = cyc;
    push_rsp(1'b1, 1'b1, 1'b1, 32'h0, s + 1);
    data_txn(1'b1, 32'h203, MSZ_HALF, 32'h5555);
    i_dreq = 1'b0;
    idle(2);
    s = cyc;
    push_rsp(1'b1, 1'b1, 1'b0, 32'h0, s + 1);
    data_txn(1'b0, 32'h500, MSZ_NONE, 32'h0);
    i_dreq = 1'b0;
    idle(2);

    // streak: data wins 4 times, then the pending fetch, then the last load
    for (int i = 0; i < 4; i++) begin
      push_m(1'b0, 4'b0000, 32'h500 + 4 * i, 32'h0, NO_CYC);
      push_rsp(1'b1, 1'b1, 1'b0, 32'h5A5A_0500 + 4 * i, NO_CYC);
    end
    push_m(1'b0, 4'b0000, 32'h100, 32'h0, NO_CYC);
    push_rsp(1'b0, 1'b1, 1'b0, 32'h0050_0093, NO_CYC);
    push_m(1'b0, 4'b0000, 32'h510, 32'h0, NO_CYC);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h5A5A_0510, NO_CYC);
    fork
      begin
        fetch_txn(32'h100);
        i_ireq = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) data_txn(1'b0, 32'h500 + 4 * i, MSZ_WORD, 32'h0);
        i_dreq = 1'b0;
      end
    join
    idle(2);

    // streak was cleared: data wins the next contest again
    push_m(1'b0, 4'b0000, 32'h520, 32'h0, NO_CYC);
    push_rsp(1'b1, 1'b1, 1'b0, 32'h5A5A_0520, NO_CYC);
    push_m(1'b0, 4'b0000, 32'h104, 32'h0, NO_CYC);
    push_rsp(1'b0, 1'b1, 1'b0, 32'h5A5A_0104, NO_CYC);
    fork
      begin
        fetch_txn(32'h104);
        i_ireq = 1'b0;
      end
      begin
        data_txn(1'b0, 32'h520, MSZ_WORD, 32'h0);
        i_dreq = 1'b0;
      end
    join
    idle(2);

    // timeouts: data gets derr, fetch gets a NOP
    mem_waits = 100000;
    s = cyc;
    push_m(1'b0, 4'b0000, 32'h600, 32'h0, s + 1);
    push_rsp(1'b1, 1'b0, 1'b1, 32'h0, s + 1 + TIMEOUT);
    data_txn(1'b0, 32'h600, MSZ_WORD, 32'h0);
    i_dreq = 1'b0;
    idle(2);
    s = cyc;
    push_m(1'b0, 4'b0000, 32'h700, 32'h0, s + 1);
    push_rsp(1'b0, 1'b1, 1'b0, NOP_INST, s + 1 + TIMEOUT);
    fetch_txn(32'h700);
    i_ireq = 1'b0;
    idle(2);

    // reset while in MEM: request dropped, no valid pulse afterwards
    s = cyc;
    push_m(1'b0, 4'b0000, 32'h800, 32'h0, s + 1);
    i_dreq = 1'b1; i_dwrite = 1'b0; i_daddr = 32'h800; i_dsize = MSZ_WORD;
    idle(2);
    check("mreq_before_reset", {31'b0, o_mreq}, 32'd1);
    i_rst = 1'b1;
    i_dreq = 1'b0;
    idle(1);
    check("mreq_after_reset", {31'b0, o_mreq}, 32'd0);
    check("state_after_reset", {30'b0, o_dbg_state}, {30'b0, IDLE});
    i_rst = 1'b0;
    mem_waits = 0;
    idle(6);

    check("rsp_queue_empty", exp_q.size(), 32'd0);
    check("mem_queue_empty", exp_m.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
